clk_en_gen_nch: RTL and testbench
=================================

Name: clk_en_gen_nch

Overview:
- Parametrised, multi-channel digital clock-enable generator driven from one reference clock.
- Each channel runs a phase accumulator, so it can produce an arbitrary fractional rate: f_ch = f_refclk * inc / 2^ACC_W.
- Each channel has a programmable phase offset.
- A runtime config handshake allows reprogramming, and a `locked` indication reports settled outputs.
- Feeds sample-rate strobes (ADC/filter/UART ticks) to downstream logic on the PLL output clock domain. This avoids a separate PLL per rate.

Parameters:
- NUM_CH, 4, number of independent channels (1..16)
- ACC_W, 32, accumulator / increment / phase width in bits (8..48)
- LOCK_CYCLES, 16, cycles `locked` stays low after reset or any config apply (>=1)

Ports:
- refclk  in  1  sole clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  config request valid
- cfg_ready  out  1  block can accept config this cycle
- cfg_ch  in  4  target channel index
- cfg_inc  in  ACC_W  phase increment for target channel
- cfg_phase  in  ACC_W  initial accumulator value loaded on apply
- cfg_err  out  1  one-cycle pulse: request had cfg_ch >= NUM_CH
- ch_enable  in  NUM_CH  per-channel run enable
- outclk_en  out  NUM_CH  per-channel single-cycle tick strobe
- outclk_sq  out  NUM_CH  per-channel square output (accumulator MSB, registered)
- locked  out  1  outputs settled since last reset/apply

Behaviour:
- Reset (rst=1 sampled on refclk edge):
  - All acc=0 and all inc=0.
  - outclk_en=0, outclk_sq=0, cfg_err=0, locked=0.
  - FSM enters LOCKING with lock counter=0.
  - cfg_ready=0 while rst=1.
- FSM states: LOCKING, RUN, APPLY.
  - LOCKING: counter increments each cycle. When counter reaches LOCK_CYCLES-1, go to RUN. `locked` rises on the first RUN cycle, exactly LOCK_CYCLES cycles after rst deasserts or after APPLY.
  - RUN: locked=1.
  - APPLY: lasts exactly 1 cycle, then LOCKING with counter cleared. locked=0 during APPLY and LOCKING.
- Handshake:
  - cfg_ready=1 in LOCKING and RUN; cfg_ready=0 in APPLY and during reset.
  - A transfer occurs when cfg_valid & cfg_ready. The request is registered and the next state is APPLY.
  - In APPLY: inc[cfg_ch]<=cfg_inc and acc[cfg_ch]<=cfg_phase. Other channels are unaffected and keep running.
  - Invalid index (cfg_ch >= NUM_CH): the request is accepted, cfg_err pulses the following cycle, there is no APPLY and no state change, and locked is unaffected.
  - cfg_valid may stay high. Back-to-back requests are accepted every second cycle.
- Per-channel datapath, when ch_enable[i]=1 and channel i is not being loaded:
  - {carry, acc[i]} <= acc[i] + inc[i], computed ACC_W+1 wide.
  - outclk_en[i] <= carry.
  - outclk_sq[i] <= MSB of the new acc[i].
- Latency: a strobe appears in the cycle after the overflowing add. It is never more than 1 cycle wide, and it is never adjacent to another strobe unless inc > 2^(ACC_W-1).
- ch_enable[i]=0: acc[i] holds, outclk_en[i]=0, outclk_sq[i] holds its last value. Re-enabling resumes from the held phase.
- Boundary conditions:
  - inc=0: never strobes.
  - inc=2^ACC_W-1: strobes on all but one of every 2^ACC_W cycles.
  - Wrap-around is modulo 2^ACC_W with no accumulated error.
  - APPLY on a disabled channel loads values; the channel stays idle until enabled.
- Simultaneous events: rst has priority over everything. An in-flight APPLY is discarded on reset.

Decomposition:
- Shared package clk_gen_pkg:
  - FSM state enum (LOCKING, RUN, APPLY).
  - Lock counter width function clog2(LOCK_CYCLES).
  - Max-channel constant (16).
- One natural sub-module: clk_en_acc. It is a single channel accumulator with inputs load, load_val, inc, enable and outputs tick, sq. It is instantiated NUM_CH times via generate.
- The top level holds the FSM, config register, index decode and lock counter.

Test Plan:
- Reset release, ACC_W=32, LOCK_CYCLES=16 -> locked=0 for 16 cycles, then 1; all outclk_en=0; cfg_ready=1 from the first post-reset cycle.
- Config ch0 inc=2^30, phase=0, enable=1 -> one APPLY cycle; first outclk_en[0] on the 4th enabled cycle after APPLY, then every 4 cycles; outclk_sq[0] has a 2-high/2-low pattern.
- Fractional rate: ch1 inc=0x6000_0000 -> 3 strobes per 8 cycles over 800 cycles (exactly 300); ch2 with phase=0xC000_0000 and inc=2^30 -> first strobe on the 1st cycle after APPLY.
- cfg_ch=7 with NUM_CH=4 -> cfg_err pulse 1 cycle later; no APPLY; locked stays 1; no inc changes.
- Reconfig ch0 while ch1 runs -> ch1 strobe cadence is uninterrupted; locked drops for 1+16 cycles; cfg_ready=0 only in the APPLY cycle.
- rst asserted the cycle after a transfer -> APPLY suppressed; all accumulators=0, locked=0; no outclk_en pulses until reconfigured.

Source files
------------

// File: rtl/clk_gen_pkg.sv
// Shared types and helpers for the multi-channel clock-enable generator.
package clk_gen_pkg;

  localparam int unsigned MAX_CH = 16;

  typedef enum logic [1:0] {
    StLocking,
    StRun,
    StApply
  } gen_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    int unsigned span;
    width = 0;
    span  = 1;
    while (span < value) begin
      span  = span << 1;
      width = width + 1;
    end
    return width;
  endfunction

  localparam int unsigned CH_IDX_W = clog2(MAX_CH);

endpackage

// File: rtl/clk_en_acc.sv
// One phase-accumulator channel: carry out of the add becomes a one-cycle tick,
// the accumulator MSB becomes a registered square wave.
module clk_en_acc
  import clk_gen_pkg::*;
#(
  parameter int unsigned ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic [ACC_W-1:0] load_val,
  input  logic [ACC_W-1:0] inc,
  output logic             tick,
  output logic             sq
);

  logic [ACC_W-1:0] acc_q;
  logic             tick_q;
  logic             sq_q;
  logic [ACC_W:0]   sum;

  assign sum = {1'b0, acc_q} + {1'b0, inc};

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      tick_q <= 1'b0;
      sq_q   <= 1'b0;
    end else if (load) begin
      // A load replaces the phase outright; no tick is produced for that cycle.
      acc_q  <= load_val;
      tick_q <= 1'b0;
    end else if (enable) begin
      acc_q  <= sum[ACC_W-1:0];
      tick_q <= sum[ACC_W];
      sq_q   <= sum[ACC_W-1];
    end else begin
      tick_q <= 1'b0;
    end
  end

  assign tick = tick_q;
  assign sq   = sq_q;

endmodule

// File: rtl/clk_en_gen_nch.sv
// Multi-channel fractional clock-enable generator with a config handshake and
// a lock indication that covers reset release and every channel reprogram.
module clk_en_gen_nch
  import clk_gen_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned ACC_W       = 32,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_IDX_W-1:0] cfg_ch,
  input  logic [ACC_W-1:0]    cfg_inc,
  input  logic [ACC_W-1:0]    cfg_phase,
  output logic                cfg_err,
  input  logic [NUM_CH-1:0]   ch_enable,
  output logic [NUM_CH-1:0]   outclk_en,
  output logic [NUM_CH-1:0]   outclk_sq,
  output logic                locked
);

  localparam int unsigned CNT_W = (clog2(LOCK_CYCLES) > 0) ? clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);

  gen_state_e          state_q;
  logic [CNT_W-1:0]    lock_cnt_q;
  logic                cfg_err_q;
  logic [CH_IDX_W-1:0] req_ch_q;
  logic [ACC_W-1:0]    req_inc_q;
  logic [ACC_W-1:0]    req_phase_q;
  logic [ACC_W-1:0]    inc_q [NUM_CH];
  logic [NUM_CH-1:0]   load;
  logic                xfer;
  logic                ch_ok;

  assign cfg_ready = ~rst & (state_q != StApply);
  assign xfer      = cfg_valid & cfg_ready;
  assign ch_ok     = 32'(cfg_ch) < NUM_CH;
  assign cfg_err   = cfg_err_q;
  assign locked    = (state_q == StRun);

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= StLocking;
      lock_cnt_q  <= '0;
      cfg_err_q   <= 1'b0;
      req_ch_q    <= '0;
      req_inc_q   <= '0;
      req_phase_q <= '0;
    end else begin
      // Out-of-range requests are consumed and flagged, leaving the FSM alone.
      cfg_err_q <= xfer & ~ch_ok;
      if (xfer && ch_ok) begin
        req_ch_q    <= cfg_ch;
        req_inc_q   <= cfg_inc;
        req_phase_q <= cfg_phase;
      end
      unique case (state_q)
        StLocking: begin
          if (xfer && ch_ok) begin
            state_q <= StApply;
          end else if (lock_cnt_q == LOCK_LAST) begin
            state_q <= StRun;
          end else begin
            lock_cnt_q <= lock_cnt_q + CNT_W'(1);
          end
        end
        StRun: begin
          if (xfer && ch_ok) begin
            state_q <= StApply;
          end
        end
        StApply: begin
          state_q    <= StLocking;
          lock_cnt_q <= '0;
        end
        default: begin
          state_q    <= StLocking;
          lock_cnt_q <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        inc_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (load[i]) begin
          inc_q[i] <= req_inc_q;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
    assign load[g] = (state_q == StApply) && (req_ch_q == CH_IDX_W'(g));

    clk_en_acc #(
      .ACC_W(ACC_W)
    ) u_acc (
      .clk     (refclk),
      .rst     (rst),
      .enable  (ch_enable[g]),
      .load    (load[g]),
      .load_val(req_phase_q),
      .inc     (inc_q[g]),
      .tick    (outclk_en[g]),
      .sq      (outclk_sq[g])
    );
  end

endmodule

// File: tb/tb_clk_en_gen_nch.sv
// Directed bench for clk_en_gen_nch. Edge k means the k-th rising edge after the
// APPLY cycle's own edge (the one that loads the channel); outputs are read #1 later.
module tb_clk_en_gen_nch;

  localparam int unsigned NumCh      = 4;
  localparam int unsigned AccW       = 32;
  localparam int unsigned LockCycles = 16;

  logic             refclk    = 1'b0;
  logic             rst       = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [3:0]       cfg_ch    = '0;
  logic [AccW-1:0]  cfg_inc   = '0;
  logic [AccW-1:0]  cfg_phase = '0;
  logic             cfg_err;
  logic [NumCh-1:0] ch_enable = '0;
  logic [NumCh-1:0] outclk_en;
  logic [NumCh-1:0] outclk_sq;
  logic             locked;

  int checks = 0;
  int errors = 0;

  always #5 refclk = ~refclk;

  clk_en_gen_nch #(
    .NUM_CH     (NumCh),
    .ACC_W      (AccW),
    .LOCK_CYCLES(LockCycles)
  ) dut (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_inc  (cfg_inc),
    .cfg_phase(cfg_phase),
    .cfg_err  (cfg_err),
    .ch_enable(ch_enable),
    .outclk_en(outclk_en),
    .outclk_sq(outclk_sq),
    .locked   (locked)
  );

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one request for a single edge (the transfer edge).
  task automatic send(input logic [3:0] ch, input logic [AccW-1:0] inc,
                      input logic [AccW-1:0] ph);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_inc   = inc;
    cfg_phase = ph;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic apply_cfg(input logic [3:0] ch, input logic [AccW-1:0] inc,
                           input logic [AccW-1:0] ph);
    send(ch, inc, ph);
    chk("apply_ready", cfg_ready, 1'b0);
    chk("apply_locked", locked, 1'b0);
    step();
    chk("post_apply_ready", cfg_ready, 1'b1);
  endtask

  initial begin
    int c0;
    int c1;
    int c2;
    int c3;
    int adj;
    int unlocked;
    int any_tick;
    logic prev1;

    // Reset state
    repeat (3) step();
    chk("rst_ready", cfg_ready, 1'b0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_en", outclk_en, 4'h0);
    chk("rst_sq", outclk_sq, 4'h0);
    chk("rst_err", cfg_err, 1'b0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", cfg_ready, 1'b1);
    chk("locked_cycle0", locked, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("lock_release", locked, k == 16);
      chk("en_idle", outclk_en, 4'h0);
    end

    // ch0: quarter rate, 2-high/2-low square
    ch_enable = 4'b0001;
    apply_cfg(4'd0, 32'h4000_0000, 32'h0);
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("ch0_tick", outclk_en[0], (k % 4) == 0);
      chk("ch0_sq", outclk_sq[0], (k % 4) >= 2);
      chk("ch0_lock", locked, k == 16);
    end

    // ch1: 3/8 rate over 800 edges while ch0 keeps its cadence
    ch_enable = 4'b0011;
    apply_cfg(4'd1, 32'h6000_0000, 32'h0);
    c0 = 0;
    c1 = 0;
    adj = 0;
    prev1 = 1'b0;
    for (int k = 1; k <= 800; k++) begin
      step();
      c0 += int'(outclk_en[0]);
      c1 += int'(outclk_en[1]);
      if (prev1 && outclk_en[1]) adj++;
      prev1 = outclk_en[1];
    end
    chk("ch1_count800", c1, 300);
    chk("ch0_count800", c0, 200);
    chk("ch1_adjacent", adj, 0);

    // ch2: phase 0xC000_0000 overflows on the first add
    ch_enable = 4'b0111;
    apply_cfg(4'd2, 32'h4000_0000, 32'hC000_0000);
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("ch2_tick", outclk_en[2], (k % 4) == 1);
      chk("ch2_lock", locked, k == 16);
    end

    // Invalid channel index: error pulse only, rates unchanged
    ch_enable = 4'b1111;
    send(4'd7, 32'h1234_5678, 32'h9ABC_DEF0);
    chk("err_pulse", cfg_err, 1'b1);
    chk("err_ready", cfg_ready, 1'b1);
    chk("err_locked", locked, 1'b1);
    step();
    chk("err_clear", cfg_err, 1'b0);
    c0 = 0;
    c1 = 0;
    c2 = 0;
    c3 = 0;
    unlocked = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      c0 += int'(outclk_en[0]);
      c1 += int'(outclk_en[1]);
      c2 += int'(outclk_en[2]);
      c3 += int'(outclk_en[3]);
      if (!locked) unlocked++;
    end
    chk("err_ch0_rate", c0, 4);
    chk("err_ch1_rate", c1, 6);
    chk("err_ch2_rate", c2, 4);
    chk("inc0_ch3_quiet", c3, 0);
    chk("err_locked_held", unlocked, 0);

    // Disable ch2, then resume
    ch_enable = 4'b1011;
    c2 = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      c2 += int'(outclk_en[2]);
    end
    chk("ch2_disabled", c2, 0);
    ch_enable = 4'b1111;
    c2 = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      c2 += int'(outclk_en[2]);
    end
    chk("ch2_resumed", c2, 4);

    // Reprogram ch0 to 1/8 rate while ch1 keeps running
    send(4'd0, 32'h2000_0000, 32'h0);
    c1 = int'(outclk_en[1]);
    chk("reconf_ready", cfg_ready, 1'b0);
    chk("reconf_locked", locked, 1'b0);
    c0 = 0;
    for (int j = 1; j <= 31; j++) begin
      step();
      c1 += int'(outclk_en[1]);
      if (j >= 2) c0 += int'(outclk_en[0]);
      chk("reconf_ready_run", cfg_ready, 1'b1);
      chk("reconf_lock", locked, j >= 17);
    end
    chk("ch1_cadence", c1, 12);
    chk("ch0_new_rate", c0, 3);

    // Reset right after a transfer discards the pending APPLY
    send(4'd3, 32'h4000_0000, 32'h0);
    rst = 1'b1;
    #1;
    chk("rst_hold_ready", cfg_ready, 1'b0);
    step();
    chk("rst2_en", outclk_en, 4'h0);
    chk("rst2_sq", outclk_sq, 4'h0);
    chk("rst2_locked", locked, 1'b0);
    rst = 1'b0;
    any_tick = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (outclk_en != 4'h0) any_tick++;
      chk("rst2_lock", locked, k >= 16);
    end
    chk("post_rst_quiet", any_tick, 0);

    // ch3 works once reconfigured
    apply_cfg(4'd3, 32'h4000_0000, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("ch3_tick", outclk_en[3], (k % 4) == 0);
      chk("ch3_others", outclk_en[2:0], 3'b000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
